// File: rtl/sr_debug_ctrl.sv
// Debug controller for a single-issue CPU: halts, runs and single-steps the core,
// honours a PC breakpoint and reads the register file through a one-entry response buffer.
module sr_debug_ctrl #(
    parameter bit RESET_RUN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_arg,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_status,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] cpu_pc,
    input  logic        invalid_instr,
    output logic        cpu_en,
    output logic [4:0]  debug_reg_addr,
    input  logic [31:0] debug_reg_data,
    output logic        halted,
    output logic [1:0]  halt_cause
);

    typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP, S_READ} state_t;

    localparam logic [1:0] OP_HALT = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_READ = 2'd3;

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_BP  = 2'd1;
    localparam logic [1:0] ST_ILL = 2'd2;
    localparam logic [1:0] ST_REJ = 2'd3;

    state_t      state_reg;
    logic [5:0]  count_reg;
    logic        skip_bp_reg;
    logic        rsp_live_reg;
    logic [31:0] rsp_data_reg;

    logic        active;
    logic        bp_hit;
    logic        cmd_fire;
    logic        fault_stop;
    logic        step_done;
    logic [1:0]  stop_status;

    assign active     = (state_reg == S_RUN) || (state_reg == S_STEP);
    assign bp_hit     = bp_en && (cpu_pc == bp_addr) && !skip_bp_reg;
    assign cpu_en     = rst_n && active && !bp_hit;
    assign cmd_ready  = !rsp_valid && ((state_reg == S_HALT) || (state_reg == S_RUN));
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign halted     = (state_reg == S_HALT);
    assign fault_stop = bp_hit || (cpu_en && invalid_instr);
    assign step_done  = fault_stop || (cpu_en && (count_reg == 6'd1));

    // A stop that retires an instruction reports the PC of the cycle after it;
    // the core is frozen by then, so that cycle's PC is forwarded live and latched.
    assign rsp_data = rsp_live_reg ? cpu_pc : rsp_data_reg;

    always_comb begin
        stop_status = ST_OK;
        if (bp_hit) begin
            stop_status = ST_BP;
        end else if (cpu_en && invalid_instr) begin
            stop_status = ST_ILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RESET_RUN ? S_RUN : S_HALT;
            count_reg      <= 6'd0;
            skip_bp_reg    <= 1'b1;
            rsp_live_reg   <= 1'b0;
            rsp_data_reg   <= 32'd0;
            rsp_valid      <= 1'b0;
            rsp_status     <= ST_OK;
            debug_reg_addr <= 5'd0;
            halt_cause     <= ST_OK;
        end else begin
            if (rsp_live_reg) begin
                rsp_data_reg <= cpu_pc;
                rsp_live_reg <= 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            case (state_reg)
                S_HALT: begin
                    if (cmd_fire) begin
                        case (cmd_op)
                            OP_RUN: begin
                                state_reg    <= S_RUN;
                                skip_bp_reg  <= 1'b1;
                                rsp_valid    <= 1'b1;
                                rsp_status   <= ST_OK;
                                rsp_data_reg <= cpu_pc;
                            end
                            OP_STEP: begin
                                state_reg   <= S_STEP;
                                skip_bp_reg <= 1'b1;
                                count_reg   <= {1'b0, cmd_arg} + 6'd1;
                            end
                            OP_READ: begin
                                state_reg      <= S_READ;
                                skip_bp_reg    <= 1'b1;
                                debug_reg_addr <= cmd_arg;
                            end
                            default: begin
                                rsp_valid    <= 1'b1;
                                rsp_status   <= ST_OK;
                                rsp_data_reg <= cpu_pc;
                            end
                        endcase
                    end
                end

                S_RUN: begin
                    skip_bp_reg <= 1'b0;
                    if (cmd_fire) begin
                        rsp_valid <= 1'b1;
                        case (cmd_op)
                            OP_HALT: begin
                                rsp_status   <= stop_status;
                                rsp_live_reg <= 1'b1;
                            end
                            OP_RUN: begin
                                rsp_status   <= ST_OK;
                                rsp_data_reg <= cpu_pc;
                            end
                            default: begin
                                rsp_status   <= ST_REJ;
                                rsp_data_reg <= 32'd0;
                            end
                        endcase
                    end
                    // Breakpoint and illegal-instruction stops are silent unless a HALT was accepted
                    if (fault_stop || (cmd_fire && (cmd_op == OP_HALT))) begin
                        state_reg  <= S_HALT;
                        halt_cause <= stop_status;
                    end
                end

                S_STEP: begin
                    skip_bp_reg <= 1'b0;
                    if (cpu_en) begin
                        count_reg <= count_reg - 6'd1;
                    end
                    if (step_done) begin
                        state_reg    <= S_HALT;
                        halt_cause   <= stop_status;
                        rsp_valid    <= 1'b1;
                        rsp_status   <= stop_status;
                        rsp_live_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg    <= S_HALT;
                    rsp_valid    <= 1'b1;
                    rsp_status   <= ST_OK;
                    rsp_data_reg <= debug_reg_data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_debug_ctrl.sv
// Directed bench for sr_debug_ctrl: a PC-counting CPU model and register file drive the
// controller through a vector table of halted-state commands plus run/breakpoint/reset sequences.
module tb_sr_debug_ctrl;

    localparam logic [1:0] OP_HALT = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_READ = 2'd3;
    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_BP   = 2'd1;
    localparam logic [1:0] ST_ILL  = 2'd2;
    localparam logic [1:0] ST_REJ  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_arg;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] cpu_pc = 32'd0;
    logic        invalid_instr;
    logic        cpu_en;
    logic [4:0]  debug_reg_addr;
    logic [31:0] debug_reg_data;
    logic        halted;
    logic [1:0]  halt_cause;

    logic        pc_load;
    logic [31:0] pc_load_val;
    logic        ill_en;
    logic [31:0] ill_pc;
    logic [31:0] regs [32];

    int errors = 0;
    int checks = 0;

    sr_debug_ctrl #(.RESET_RUN(1'b0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_arg        (cmd_arg),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_status     (rsp_status),
        .bp_en          (bp_en),
        .bp_addr        (bp_addr),
        .cpu_pc         (cpu_pc),
        .invalid_instr  (invalid_instr),
        .cpu_en         (cpu_en),
        .debug_reg_addr (debug_reg_addr),
        .debug_reg_data (debug_reg_data),
        .halted         (halted),
        .halt_cause     (halt_cause)
    );

    always #5 clk = ~clk;

    // CPU model: straight-line code, one 4-byte instruction per enabled cycle
    always @(posedge clk) begin
        if (pc_load) cpu_pc <= pc_load_val;
        else if (cpu_en) cpu_pc <= cpu_pc + 32'd4;
    end

    assign invalid_instr  = ill_en && (cpu_pc == ill_pc);
    assign debug_reg_data = regs[debug_reg_addr];

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  op;
        logic [4:0]  arg;
        logic        bp_on;
        logic [31:0] bp;
        logic        ill_on;
        logic [31:0] ill;
        logic [1:0]  st;
        logic [31:0] data;
        int          lat;
        int          en;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command (called #1 after an edge), wait for its response, then consume it
    task automatic do_cmd(input logic [1:0] op, input logic [4:0] arg,
                          output logic [1:0] st, output logic [31:0] data,
                          output int lat, output int en_cnt, output logic [31:0] pc_acc);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        pc_acc    = cpu_pc;
        check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
        lat    = 0;
        en_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (cpu_en) en_cnt++;
            tick();
            cmd_valid = 1'b0;
            lat++;
            if (rsp_valid) break;
        end
        cmd_valid = 1'b0;
        check("rsp_arrived", {31'd0, rsp_valid}, 32'd1);
        st   = rsp_status;
        data = rsp_data;
        $display("cmd op=%0d arg=%0d -> status=%0d data=%h lat=%0d en_cycles=%0d",
                 op, arg, st, data, lat, en_cnt);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic load_pc(input logic [31:0] pc);
        pc_load     = 1'b1;
        pc_load_val = pc;
        tick();
        pc_load     = 1'b0;
    endtask

    task automatic wait_halted();
        for (int i = 0; i < 30; i++) begin
            if (halted) break;
            tick();
        end
        check("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    initial begin
        logic [1:0]  st;
        logic [31:0] data;
        logic [31:0] pc_acc;
        logic [31:0] pc0;
        int          lat;
        int          en;

        vecs[0] = '{32'h100, OP_HALT, 5'd0,  1'b0, 32'h0,   1'b0, 32'h0,   ST_OK,  32'h100,      1,  0};
        vecs[1] = '{32'h100, OP_STEP, 5'd2,  1'b0, 32'h0,   1'b0, 32'h0,   ST_OK,  32'h10C,      4,  3};
        vecs[2] = '{32'h200, OP_STEP, 5'd0,  1'b0, 32'h0,   1'b0, 32'h0,   ST_OK,  32'h204,      2,  1};
        vecs[3] = '{32'h200, OP_STEP, 5'd31, 1'b0, 32'h0,   1'b0, 32'h0,   ST_OK,  32'h280,      33, 32};
        vecs[4] = '{32'h300, OP_STEP, 5'd31, 1'b0, 32'h0,   1'b1, 32'h308, ST_ILL, 32'h30C,      4,  3};
        vecs[5] = '{32'h0,   OP_READ, 5'd5,  1'b0, 32'h0,   1'b0, 32'h0,   ST_OK,  32'hDEADBEEF, 2,  0};
        vecs[6] = '{32'h0,   OP_READ, 5'd31, 1'b0, 32'h0,   1'b0, 32'h0,   ST_OK,  32'h12345678, 2,  0};
        vecs[7] = '{32'h400, OP_STEP, 5'd7,  1'b1, 32'h408, 1'b0, 32'h0,   ST_BP,  32'h408,      4,  2};

        for (int i = 0; i < 32; i++) regs[i] = 32'h01010101 * i;
        regs[5]  = 32'hDEADBEEF;
        regs[31] = 32'h12345678;

        rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 5'd0; rsp_ready = 1'b0;
        bp_en = 1'b0; bp_addr = 32'd0; pc_load = 1'b0; pc_load_val = 32'd0;
        ill_en = 1'b0; ill_pc = 32'd0;
        #3 rst_n = 1'b0;
        tick();
        tick();
        check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_status", {30'd0, rsp_status}, 32'd0);
        check("rst_dbg_addr", {27'd0, debug_reg_addr}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd1);
        check("rst_halt_cause", {30'd0, halt_cause}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_halted", {31'd0, halted}, 32'd1);

        for (int v = 0; v < 8; v++) begin
            bp_en   = vecs[v].bp_on;
            bp_addr = vecs[v].bp;
            ill_en  = vecs[v].ill_on;
            ill_pc  = vecs[v].ill;
            load_pc(vecs[v].pc);
            do_cmd(vecs[v].op, vecs[v].arg, st, data, lat, en, pc_acc);
            check($sformatf("vec%0d_status", v), {30'd0, st}, {30'd0, vecs[v].st});
            check($sformatf("vec%0d_data", v), data, vecs[v].data);
            check($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
            check($sformatf("vec%0d_en_cycles", v), en, vecs[v].en);
            check($sformatf("vec%0d_halted", v), {31'd0, halted}, 32'd1);
            if (vecs[v].op == OP_STEP)
                check($sformatf("vec%0d_cause", v), {30'd0, halt_cause}, {30'd0, vecs[v].st});
            if (vecs[v].op == OP_READ)
                check($sformatf("vec%0d_dbg_addr", v), {27'd0, debug_reg_addr}, {27'd0, vecs[v].arg});
        end
        ill_en = 1'b0;

        // RUN into a breakpoint, then step over it
        bp_en = 1'b1; bp_addr = 32'h10;
        load_pc(32'h0);
        do_cmd(OP_RUN, 5'd0, st, data, lat, en, pc_acc);
        check("bp_run_status", {30'd0, st}, {30'd0, ST_OK});
        check("bp_run_data", data, 32'h0);
        wait_halted();
        check("bp_stop_pc", cpu_pc, 32'h10);
        check("bp_cause", {30'd0, halt_cause}, {30'd0, ST_BP});
        check("bp_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("bp_cpu_en", {31'd0, cpu_en}, 32'd0);
        do_cmd(OP_STEP, 5'd0, st, data, lat, en, pc_acc);
        check("bp_step_status", {30'd0, st}, {30'd0, ST_OK});
        check("bp_step_data", data, 32'h14);
        check("bp_step_en", en, 1);

        // HALT command accepted in the same cycle as a breakpoint hit
        bp_addr = 32'h608;
        load_pc(32'h600);
        do_cmd(OP_RUN, 5'd0, st, data, lat, en, pc_acc);
        check("bph_run_data", data, 32'h600);
        for (int i = 0; i < 10; i++) begin
            if (cpu_pc == 32'h608) break;
            tick();
        end
        check("bph_align_pc", cpu_pc, 32'h608);
        do_cmd(OP_HALT, 5'd0, st, data, lat, en, pc_acc);
        check("bph_status", {30'd0, st}, {30'd0, ST_BP});
        check("bph_data", data, 32'h608);
        check("bph_latency", lat, 1);
        check("bph_cause", {30'd0, halt_cause}, {30'd0, ST_BP});
        check("bph_halted", {31'd0, halted}, 32'd1);

        // Response held under backpressure, then STEP rejected while running, then HALT
        bp_en = 1'b0;
        load_pc(32'h500);
        cmd_valid = 1'b1; cmd_op = OP_RUN; cmd_arg = 5'd0;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("hold%0d_data", i), rsp_data, 32'h500);
            check($sformatf("hold%0d_status", i), {30'd0, rsp_status}, {30'd0, ST_OK});
            check($sformatf("hold%0d_cmd_ready", i), {31'd0, cmd_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        do_cmd(OP_STEP, 5'd3, st, data, lat, en, pc_acc);
        check("rej_status", {30'd0, st}, {30'd0, ST_REJ});
        check("rej_data", data, 32'h0);
        check("rej_still_run", {31'd0, halted}, 32'd0);
        do_cmd(OP_HALT, 5'd0, st, data, lat, en, pc_acc);
        check("runhalt_status", {30'd0, st}, {30'd0, ST_OK});
        check("runhalt_data", data, pc_acc + 32'd4);
        check("runhalt_halted", {31'd0, halted}, 32'd1);
        check("runhalt_cause", {30'd0, halt_cause}, {30'd0, ST_OK});

        // Illegal instruction while running stops silently
        ill_en = 1'b1; ill_pc = 32'h708;
        load_pc(32'h700);
        do_cmd(OP_RUN, 5'd0, st, data, lat, en, pc_acc);
        wait_halted();
        check("ill_cause", {30'd0, halt_cause}, {30'd0, ST_ILL});
        check("ill_no_rsp", {31'd0, rsp_valid}, 32'd0);
        ill_en = 1'b0;

        // Reset in the middle of a STEP
        load_pc(32'h800);
        cmd_valid = 1'b1; cmd_op = OP_STEP; cmd_arg = 5'd20;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("midstep_cpu_en", {31'd0, cpu_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("arst_halted", {31'd0, halted}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("rel_halted", {31'd0, halted}, 32'd1);
        check("rel_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        pc0 = cpu_pc;
        do_cmd(OP_STEP, 5'd0, st, data, lat, en, pc_acc);
        check("rel_step_status", {30'd0, st}, {30'd0, ST_OK});
        check("rel_step_data", data, pc0 + 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sr_debug_ctrl.md
SR_DEBUG_CTRL -- requirements
Module: sr_debug_ctrl

Interface
REQ-001 Parameter: RESET_RUN, default 0, 1 = enter RUN directly on reset release, 0 = enter HALT.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 cmd_valid / cmd_ready  input/output  1/1  command handshake; transfer on cycle where both are high.
REQ-005 cmd_op  input  2  0 HALT, 1 RUN, 2 STEP, 3 READ.
REQ-006 cmd_arg  input  5  STEP: count-1 (1..32 instructions); READ: register index; otherwise ignored.
REQ-007 rsp_valid / rsp_ready  output/input  1/1  response handshake, single-entry buffer.
REQ-008 rsp_data  output  32  PC or register value.
REQ-009 rsp_status  output  2  0 OK, 1 BREAKPOINT, 2 ILLEGAL, 3 REJECT.
REQ-010 bp_en, bp_addr  input  1, 32  breakpoint enable and byte address.
REQ-011 cpu_pc  input  32  current CPU program counter.
REQ-012 invalid_instr  input  1  CPU illegal-instruction flag, same cycle as cpu_pc.
REQ-013 cpu_en  output  1  CPU clock enable; CPU retires one instruction per cycle with cpu_en=1.
REQ-014 debug_reg_addr  output  5  register file debug address (registered).
REQ-015 debug_reg_data  input  32  register file debug data (combinational from debug_reg_addr).
REQ-016 halted, halt_cause  output  1, 2  halted = state HALT; halt_cause encoded as rsp_status of last stop.

Function
REQ-017 States: HALT, RUN, STEP, READ; one-hot or binary at implementer's choice.
REQ-018 cmd_ready = !rsp_valid && (state==HALT || state==RUN).
REQ-019 bp_hit = bp_en && cpu_pc==bp_addr && !skip_bp; skip_bp set on every transition out of HALT, cleared after first cycle in RUN/STEP.
REQ-020 cpu_en = (state==RUN || state==STEP) && !bp_hit, combinational; 0 in HALT and READ.
REQ-021 HALT + RUN cmd -> RUN next cycle; response OK, rsp_data = cpu_pc at accept, rsp_valid next cycle.
REQ-022 HALT + STEP cmd -> load counter = cmd_arg+1, STEP next cycle; counter decrements each cycle with cpu_en=1.
REQ-023 STEP ends when counter reaches 0 (status OK), on bp_hit (BREAKPOINT), or on invalid_instr with cpu_en=1 (ILLEGAL); -> HALT, response with rsp_data = cpu_pc of following cycle, rsp_valid one cycle after final STEP cycle.
REQ-024 HALT + READ cmd -> debug_reg_addr <= cmd_arg, READ for exactly one cycle, rsp_data <= debug_reg_data at end of READ, status OK, -> HALT; rsp_valid 2 cycles after accept.
REQ-025 HALT + HALT cmd -> stay HALT, response OK, rsp_data = cpu_pc.
REQ-026 RUN + HALT cmd -> HALT next cycle, cpu_en still 1 in accept cycle, response OK, rsp_data = cpu_pc after that instruction.
REQ-027 RUN + STEP/READ cmd -> state unchanged, response REJECT, rsp_data = 0.
REQ-028 RUN: bp_hit -> HALT, halt_cause BREAKPOINT, instruction at bp_addr not executed, no response generated.
REQ-029 RUN: invalid_instr with cpu_en=1 -> HALT, halt_cause ILLEGAL, no response.
REQ-030 RUN: HALT cmd accepted same cycle as bp_hit -> HALT, response status BREAKPOINT, halt_cause BREAKPOINT.
REQ-031 Every accepted command produces exactly one response; rsp_valid, rsp_data, rsp_status held stable until rsp_ready.
REQ-032 Resuming from a breakpoint PC (RUN or STEP) executes that instruction (REQ-019 skip).

Reset
REQ-033 rst_n low: state = HALT (RESET_RUN=0) or RUN (RESET_RUN=1), cpu_en = 0 while rst_n low, rsp_valid = 0, rsp_data = 0, rsp_status = 0, debug_reg_addr = 0, counter = 0, halt_cause = 0, skip_bp = 1.
REQ-034 Reset mid-STEP/READ aborts operation; pending response discarded.

Verification
REQ-035 RESET_RUN=0, reset release, STEP arg=2 -> cpu_en high exactly 3 cycles, response OK, rsp_data = start_pc+12.
REQ-036 RUN with bp_en=1, bp_addr=0x10 -> cpu_en low when cpu_pc=0x10, halted=1, halt_cause=1; STEP arg=0 then executes 0x10, response OK, rsp_data=0x14.
REQ-037 HALT, READ arg=5 with x5=0xDEADBEEF -> debug_reg_addr=5, rsp_valid 2 cycles after accept, rsp_data=0xDEADBEEF, cpu_en never high.
REQ-038 STEP arg=31 with invalid_instr at 3rd instruction -> HALT after 3 enabled cycles, rsp_status=2.
REQ-039 RUN, rsp_ready=0 for 5 cycles -> rsp fields stable, cmd_ready=0; then RUN + STEP cmd -> REJECT, state RUN.
REQ-040 rst_n asserted mid-STEP -> cpu_en=0, rsp_valid=0 immediately, state HALT after release.
